// File: rtl/pixel_writer.sv
// Packs a stream of 8-bit pixels into 32-bit little-endian words and writes
// them to consecutive RAM word addresses starting at a latched base address.
module pixel_writer #(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_pixels,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [31:0]       data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [1:0]        lane;
    logic [31:0]       pack;
    logic              accept;
    logic              word_full;
    logic [31:0]       word_next;

    // Handshake: a pixel moves on a rising edge where pix_valid and pix_ready
    // are both high; pix_ready is registered and high exactly while in FILL.
    assign accept    = pix_valid && pix_ready;
    assign word_full = (lane == 2'd3) || (remaining == ONE_CNT);
    assign state_dbg = state;

    always_comb begin
        word_next = pack;
        word_next[{lane, 3'b000} +: 8] = pix_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            lane      <= '0;
            pack      <= '0;
            pix_ready <= 1'b0;
            wren      <= 1'b0;
            wraddress <= '0;
            data      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_pixels != '0) begin
                            addr      <= base_addr;
                            remaining <= num_pixels;
                            lane      <= '0;
                            pack      <= '0;
                            pix_ready <= 1'b1;
                            state     <= FILL;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FILL: begin
                    if (abort) begin
                        pix_ready <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (accept) begin
                        remaining <= remaining - ONE_CNT;
                        // Word is complete on the 4th lane or the transfer's
                        // last pixel; unfilled lanes stay zero from the clear.
                        if (word_full) begin
                            data      <= word_next;
                            wraddress <= addr;
                            wren      <= 1'b1;
                            pix_ready <= 1'b0;
                            state     <= WRITE;
                        end else begin
                            pack <= word_next;
                            lane <= lane + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    wren <= 1'b0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        addr <= addr + ONE_ADDR;
                        if (remaining == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            lane      <= '0;
                            pack      <= '0;
                            pix_ready <= 1'b1;
                            state     <= FILL;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed scoreboard bench for pixel_writer: the stimulus pushes expected
// {address, word} pairs and a negedge monitor pops them on every wren.
module tb_pixel_writer;

    localparam int ADDR_W = 18;
    localparam int CNT_W  = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_pixels;
    logic              abort;
    logic              pix_valid;
    logic [7:0]        pix_data;
    logic              pix_ready;
    logic              wren;
    logic [ADDR_W-1:0] wraddress;
    logic [31:0]       data;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    pixel_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_pixels(num_pixels), .abort(abort), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .wren(wren),
        .wraddress(wraddress), .data(data), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    logic [ADDR_W+31:0] exp_q[$];
    int                 wren_cyc_q[$];
    logic [7:0]         pix_buf[0:7];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_cyc = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        cyc++;
        if (wren === 1'b1) begin
            wren_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("extra_wren", 64'({wraddress, data}), 64'h0);
            end else begin
                check("wr_word", 64'({wraddress, data}), 64'(exp_q.pop_front()));
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    // driver tasks; all are entered and left 1 time unit after a rising edge
    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] n);
        start      = 1'b1;
        base_addr  = base;
        num_pixels = n;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic feed(input int first, input int cnt, input bit stall);
        int  i = 0;
        int  guard = 0;
        bit  phase = 1'b1;
        bit  word_end = 1'b0;
        while (i < cnt && guard < 100) begin
            pix_valid = stall ? phase : 1'b1;
            pix_data  = pix_buf[first + i];
            @(negedge clk);
            if (stall && !pix_valid)
                check("ready_in_stall", 64'(pix_ready), 64'(!word_end));
            word_end = 1'b0;
            if (pix_valid && pix_ready) begin
                i++;
                word_end = ((first + i) % 4 == 0);
            end
            phase = !phase;
            @(posedge clk); #1;
            guard++;
        end
        pix_valid = 1'b0;
        check("feed_count", 64'(i), 64'(cnt));
    endtask

    task automatic wait_done(input int prev);
        int k = 0;
        while (done_seen == prev && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", 64'(done_seen), 64'(prev + 1));
        @(posedge clk); #1;
    endtask

    initial begin
        int prev;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_pixels = '0;
        abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wren", 64'(wren), 64'h0);
        check("rst_ready", 64'(pix_ready), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_addr", 64'(wraddress), 64'h0);
        check("rst_data", 64'(data), 64'h0);
        check("rst_state", 64'(state_dbg), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // two full words, pix_valid always high, latency and throughput
        for (int i = 0; i < 8; i++) pix_buf[i] = 8'((i + 1) * 8'h11);
        exp_q.push_back({18'h00100, 32'h44332211});
        exp_q.push_back({18'h00101, 32'h88776655});
        wren_cyc_q.delete();
        prev = done_seen;
        do_start(18'h00100, 20'd8);
        check("busy_active", 64'(busy), 64'h1);
        feed(0, 8, 1'b0);
        wait_done(prev);
        check("t1_nwren", 64'(wren_cyc_q.size()), 64'd2);
        if (wren_cyc_q.size() == 2) begin
            check("t1_first_lat", 64'(wren_cyc_q[0] - start_cyc), 64'd5);
            check("t1_second_lat", 64'(wren_cyc_q[1] - start_cyc), 64'd10);
            check("t1_done_lat", 64'(done_cyc - wren_cyc_q[1]), 64'd1);
        end
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'h0);

        // partial final word zero-filled
        for (int i = 0; i < 8; i++) pix_buf[i] = 8'(8'hA1 + i);
        exp_q.push_back({18'h00200, 32'hA4A3A2A1});
        exp_q.push_back({18'h00201, 32'h0000A6A5});
        prev = done_seen;
        do_start(18'h00200, 20'd6);
        feed(0, 6, 1'b0);
        wait_done(prev);
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // address wrap from all-ones to zero
        for (int i = 0; i < 8; i++) pix_buf[i] = 8'(8'h01 + i);
        exp_q.push_back({18'h3FFFF, 32'h04030201});
        exp_q.push_back({18'h00000, 32'h08070605});
        prev = done_seen;
        do_start(18'h3FFFF, 20'd8);
        feed(0, 8, 1'b0);
        wait_done(prev);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // pix_valid toggling: same words, no extra wren, ready held in stall
        for (int i = 0; i < 8; i++) pix_buf[i] = 8'((i + 1) * 8'h11);
        exp_q.push_back({18'h00100, 32'h44332211});
        exp_q.push_back({18'h00101, 32'h88776655});
        wren_cyc_q.delete();
        prev = done_seen;
        do_start(18'h00100, 20'd8);
        feed(0, 8, 1'b1);
        wait_done(prev);
        check("t4_nwren", 64'(wren_cyc_q.size()), 64'd2);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // abort after two pixels of the second word, then a zero-length start
        for (int i = 0; i < 8; i++) pix_buf[i] = 8'(8'hB1 + i);
        exp_q.push_back({18'h00040, 32'hB4B3B2B1});
        wren_cyc_q.delete();
        prev = done_seen;
        do_start(18'h00040, 20'd8);
        feed(0, 6, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_ready", 64'(pix_ready), 64'h0);
        @(posedge clk); #1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_seen), 64'(prev));
        check("abort_nwren", 64'(wren_cyc_q.size()), 64'd1);
        check("abort_q_empty", 64'(exp_q.size()), 64'd0);
        wren_cyc_q.delete();
        prev = done_seen;
        do_start(18'h00055, 20'd0);
        wait_done(prev);
        check("zero_done_lat", 64'(done_cyc - start_cyc), 64'd1);
        check("zero_nwren", 64'(wren_cyc_q.size()), 64'd0);

        // start ignored mid-transfer, then reset during the WRITE cycle
        for (int i = 0; i < 8; i++) pix_buf[i] = 8'(8'hC1 + i);
        exp_q.push_back({18'h00200, 32'hC4C3C2C1});
        do_start(18'h00200, 20'd4);
        feed(0, 2, 1'b0);
        start = 1'b1; base_addr = 18'h03000; num_pixels = 20'd8;
        @(posedge clk); #1;
        start = 1'b0;
        feed(2, 2, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("wrst_wren", 64'(wren), 64'h0);
        check("wrst_ready", 64'(pix_ready), 64'h0);
        check("wrst_busy", 64'(busy), 64'h0);
        check("wrst_done", 64'(done), 64'h0);
        check("wrst_addr", 64'(wraddress), 64'h0);
        check("wrst_data", 64'(data), 64'h0);
        check("wrst_state", 64'(state_dbg), 64'h0);
        check("wrst_q_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        repeat (4) @(posedge clk);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
